// File: rtl/wide_bus_deserializer.sv
// Receive side of the narrow beat link: gathers NBEATS beats (LSB beat first) into one
// wide word, checks framing against in_last and hands the word off with valid/ready.
module wide_bus_deserializer #(
    parameter  int BEAT_W = 30,
    parameter  int NBEATS = 30,
    localparam int WORD_W = BEAT_W * NBEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              frame_err
);

    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DRAIN
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_frame_err;

    logic                w_take_word;
    logic                w_accept;
    logic                w_collecting;
    logic                w_final_slot;

    // A word leaving HOLD frees the buffer in the same cycle, so the next beat is
    // treated as beat 0 of a fresh word with no bubble.
    assign w_take_word  = (r_state == HOLD) && out_ready;
    assign in_ready     = (r_state == HOLD) ? out_ready : 1'b1;
    assign w_accept     = in_valid && in_ready;
    assign w_collecting = (r_state == COLLECT) || w_take_word;
    assign w_final_slot = (r_beat_cnt == LAST_CNT);

    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_beat_cnt  <= '0;
            r_out_data  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_take_word) begin
                r_state <= COLLECT;
            end
            if (w_accept && w_collecting) begin
                for (int k = 0; k < NBEATS; k++) begin
                    if (r_beat_cnt == CNT_W'(k)) begin
                        r_out_data[k*BEAT_W +: BEAT_W] <= in_data;
                    end
                end
                if (w_final_slot) begin
                    r_beat_cnt <= '0;
                    if (in_last) begin
                        r_state <= HOLD;
                    end else begin
                        r_state     <= DRAIN;
                        r_frame_err <= 1'b1;
                    end
                end else if (in_last) begin
                    r_beat_cnt  <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end else if (w_accept && (r_state == DRAIN) && in_last) begin
                // Resynchronise on the first in_last seen after a missing-last error.
                r_state <= COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_wide_bus_deserializer.sv
// Directed bench for wide_bus_deserializer: table of framing scenarios plus hand-written
// hold, random-handshake and reset sequences, checked against bench-built expected words.
module tb_wide_bus_deserializer;

    localparam int BW = 30;
    localparam int NB = 30;
    localparam int WW = BW * NB;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int gotWords = 0;
    int errPulses = 0;
    logic randReady = 1'b0;
    logic [WW-1:0] expQ[$];
    logic [WW-1:0] monExp;

    typedef struct {
        int          nBeats;
        int          lastAt;
        logic [31:0] base;
        logic [31:0] mult;
        int          expWords;
        int          expErrs;
    } vec_t;

    vec_t tbl[8];

    wide_bus_deserializer #(.BEAT_W(BW), .NBEATS(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] beatVal(input logic [31:0] base, input logic [31:0] mult, input int k);
        logic [31:0] v;
        v = base + mult * k;
        return v[BW-1:0];
    endfunction

    function automatic logic [WW-1:0] makeWord(input logic [31:0] base, input logic [31:0] mult);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) w[k*BW +: BW] = beatVal(base, mult, k);
        return w;
    endfunction

    function automatic int firstBadBeat(input logic [WW-1:0] act, input logic [WW-1:0] exp);
        for (int k = 0; k < NB; k++) begin
            if (act[k*BW +: BW] !== exp[k*BW +: BW]) return k;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        int bad;
        checks++;
        bad = firstBadBeat(act, exp);
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s beat %0d act=%h exp=%h", name, bad,
                     act[bad*BW +: BW], exp[bad*BW +: BW]);
        end
    endtask

    // Every delivered word is matched in order against the words the bench framed correctly.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_err === 1'b1) errPulses++;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            gotWords++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL word_unexpected act=delivered exp=none");
            end else begin
                monExp = expQ.pop_front();
                checkWord("word_data", out_data, monExp);
            end
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [BW-1:0] d, input logic l);
        logic acc;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_accept_timeout act=stalled exp=accepted");
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] base, input logic [31:0] mult,
                            input int nBeats, input int lastAt, input bit gaps);
        for (int k = 0; k < nBeats; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(beatVal(base, mult, k), (k == lastAt));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout act=running exp=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int w0;
        int e0;
        logic [WW-1:0] wA;
        logic [WW-1:0] wB;

        tbl[0] = '{30, 29, 32'h0000_0000, 32'h0000_0001, 1, 0};
        tbl[1] = '{11, 10, 32'h0000_0abc, 32'h0000_0007, 0, 1};
        tbl[2] = '{30, 29, 32'h2AAA_AAAA, 32'h0000_1111, 1, 0};
        tbl[3] = '{31, 30, 32'h0000_0500, 32'h0000_0001, 0, 1};
        tbl[4] = '{30, 29, 32'h3FFF_FFF0, 32'h0000_0001, 1, 0};
        tbl[5] = '{ 1,  0, 32'h0000_0077, 32'h0000_0000, 0, 1};
        tbl[6] = '{29, 28, 32'h0000_1234, 32'h0000_0005, 0, 1};
        tbl[7] = '{30, 29, 32'h0155_5555, 32'h0000_0101, 1, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkWord("reset_out_data", out_data, '0);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            w0 = gotWords;
            e0 = errPulses;
            if (tbl[i].expWords != 0) expQ.push_back(makeWord(tbl[i].base, tbl[i].mult));
            sendWord(tbl[i].base, tbl[i].mult, tbl[i].nBeats, tbl[i].lastAt, 1'b0);
            checkOutput($sformatf("vec%0d_valid_latency", i), 32'(out_valid), 32'(tbl[i].expWords));
            idle(3);
            checkOutput($sformatf("vec%0d_words", i), 32'(gotWords - w0), 32'(tbl[i].expWords));
            checkOutput($sformatf("vec%0d_frame_errs", i), 32'(errPulses - e0), 32'(tbl[i].expErrs));
        end

        // Back-to-back words with the consumer stalling on the first one.
        wA = makeWord(32'h0000_1000, 32'h0000_0003);
        wB = makeWord(32'h0ABC_0000, 32'h0000_0013);
        expQ.push_back(wA);
        expQ.push_back(wB);
        w0 = gotWords;
        out_ready = 1'b0;
        sendWord(32'h0000_1000, 32'h0000_0003, NB, NB - 1, 1'b0);
        in_valid = 1'b1;
        in_data  = beatVal(32'h0ABC_0000, 32'h0000_0013, 0);
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
            checkWord($sformatf("hold%0d_stable", c), out_data, wA);
            idle(1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("release_valid_drop", 32'(out_valid), 32'd0);
        for (int k = 1; k < NB; k++) begin
            applyStimulus(beatVal(32'h0ABC_0000, 32'h0000_0013, k), (k == NB - 1));
        end
        checkOutput("b2b_second_latency", 32'(out_valid), 32'd1);
        idle(2);
        checkOutput("b2b_words", 32'(gotWords - w0), 32'd2);

        // Random beat gaps and random consumer readiness.
        w0 = gotWords;
        e0 = errPulses;
        randReady = 1'b1;
        for (int n = 0; n < 5; n++) begin
            expQ.push_back(makeWord(32'h0100_0000 * n + 32'h55, 32'h0000_0101 + n));
            sendWord(32'h0100_0000 * n + 32'h55, 32'h0000_0101 + n, NB, NB - 1, 1'b1);
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int g = 0; g < 50 && expQ.size() != 0; g++) idle(1);
        checkOutput("random_pending", 32'(expQ.size()), 32'd0);
        checkOutput("random_words", 32'(gotWords - w0), 32'd5);
        checkOutput("random_frame_errs", 32'(errPulses - e0), 32'd0);

        // Reset in the middle of a word.
        w0 = gotWords;
        for (int k = 0; k < 15; k++) applyStimulus(beatVal(32'h0DEAD, 32'h1, k), 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        rst_n = 1'b1;
        expQ.push_back(makeWord(32'h0BEEF0, 32'h0000_0021));
        sendWord(32'h0BEEF0, 32'h0000_0021, NB, NB - 1, 1'b0);
        idle(2);
        checkOutput("rst_mid_next_word", 32'(gotWords - w0), 32'd1);

        // Reset while a word is being held.
        w0 = gotWords;
        out_ready = 1'b0;
        sendWord(32'h0C0FFEE, 32'h0000_0002, NB, NB - 1, 1'b0);
        checkOutput("rst_hold_valid_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hold_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_hold_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        expQ.push_back(makeWord(32'h0001_2345, 32'h0000_0777));
        sendWord(32'h0001_2345, 32'h0000_0777, NB, NB - 1, 1'b0);
        idle(2);
        checkOutput("rst_hold_next_word", 32'(gotWords - w0), 32'd1);
        checkOutput("final_pending", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
